// File: rtl/repetition_tx_pkg.sv
// Shared definitions for the 3x repetition-coded serial link (transmitter and receiver).
package repetition_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam int   DEF_REPS      = 3;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/repetition_tx_mod_counter.sv
// Modulo-MOD up-counter with synchronous clear; wrap flags the last count of a cycle.
module tx_mod_counter
    import repetition_tx_pkg::*;
#(
    parameter int MOD = DEF_REPS,
    parameter int W   = cnt_w(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en)
            count <= (count == LAST) ? '0 : count + W'(1);
    end

endmodule

// File: rtl/repetition_tx.sv
// Framed serial transmitter: start, NBITS data bits LSB first, stop; each symbol held REPS cycles.
module repetition_tx
    import repetition_tx_pkg::*;
#(
    parameter int NBITS = 8,
    parameter int REPS  = DEF_REPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_data,
    output logic             tx,
    output logic             busy
);

    localparam int RW = cnt_w(REPS);
    localparam int BW = cnt_w(NBITS);

    tx_state_e        state, state_nxt;
    logic [NBITS-1:0] shreg, shreg_nxt;
    logic             tx_nxt;
    logic [RW-1:0]    rep_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             rep_wrap, bit_wrap, xfer;

    assign in_rdy = (state == IDLE);
    assign busy   = (state != IDLE);
    assign xfer   = in_val && in_rdy;

    tx_mod_counter #(.MOD(REPS)) u_rep (
        .clk   (clk),
        .rst   (rst),
        .clear (xfer),
        .en    (busy),
        .count (rep_cnt),
        .wrap  (rep_wrap)
    );

    tx_mod_counter #(.MOD(NBITS)) u_bit (
        .clk   (clk),
        .rst   (rst),
        .clear (xfer),
        .en    ((state == DATA) && rep_wrap),
        .count (bit_cnt),
        .wrap  (bit_wrap)
    );

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        case (state)
            IDLE: if (xfer) begin
                state_nxt = START;
                shreg_nxt = in_data;
            end
            START: if (rep_wrap) state_nxt = DATA;
            DATA: if (rep_wrap) begin
                shreg_nxt = shreg >> 1;
                if (bit_wrap) state_nxt = STOP;
            end
            STOP: if (rep_wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tx is registered from the next state so the line level lines up with the state it encodes.
    always_comb begin
        tx_nxt = TX_IDLE_LEVEL;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            default: tx_nxt = TX_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            tx    <= TX_IDLE_LEVEL;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            tx    <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_repetition_tx.sv
// Bench for repetition_tx: vector table plus scoreboard of expected frames and majority-vote decode.
module tb_repetition_tx;
    import repetition_tx_pkg::*;

    localparam int NB = 8;
    localparam int R  = 3;
    localparam int FL = R * (NB + 2);

    logic          clk = 1'b0;
    logic          rst, in_val, in_rdy, tx, busy;
    logic [NB-1:0] in_data;

    always #5 clk = ~clk;

    repetition_tx #(.NBITS(NB), .REPS(R)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .tx      (tx),
        .busy    (busy)
    );

    typedef struct {
        logic [NB-1:0] data;
        logic [FL-1:0] frame;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [FL-1:0] sb_frame[$];
    logic [NB-1:0] sb_word[$];
    vec_t vt[6];

    function automatic logic [FL-1:0] model_frame(input logic [NB-1:0] d);
        logic [FL-1:0] f;
        for (int i = 0; i < FL; i++) begin
            if (i < R)                f[i] = 1'b0;
            else if (i < R * (NB + 1)) f[i] = d[(i - R) / R];
            else                      f[i] = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [NB-1:0] vote(input logic [FL-1:0] f);
        logic [NB-1:0] v;
        logic a, b, c;
        for (int k = 0; k < NB; k++) begin
            a = f[R * (k + 1)];
            b = f[R * (k + 1) + 1];
            c = f[R * (k + 1) + 2];
            v[k] = (a & b) | (a & c) | (b & c);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Wait (bounded) for an IDLE negedge, present the word, and record the expected frame.
    task automatic send(input logic [NB-1:0] d, input logic [FL-1:0] exp, input bit hold);
        int n = 0;
        @(negedge clk);
        while (!in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rdy_wait", 32'(n < 100), 32'd1);
        in_val = 1'b1;
        in_data = d;
        sb_frame.push_back(exp);
        sb_word.push_back(d);
        @(posedge clk);
        #1;
        if (!hold) in_val = 1'b0;
    endtask

    // Sample FL cycles of tx, then check the following IDLE cycle just after its opening edge.
    task automatic capture(input string name, input bit scramble);
        logic [FL-1:0] f;
        logic [FL-1:0] ef;
        logic [NB-1:0] ew;
        bit bz = 1'b1;
        bit rz = 1'b1;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            f[i] = tx;
            if (busy !== 1'b1)  bz = 1'b0;
            if (in_rdy !== 1'b0) rz = 1'b0;
            if (scramble) in_data = NB'($urandom);
        end
        ef = sb_frame.pop_front();
        ew = sb_word.pop_front();
        check({name, "_tx"},    32'(f), 32'(ef));
        check({name, "_busy"},  32'(bz), 32'd1);
        check({name, "_rdy0"},  32'(rz), 32'd1);
        check({name, "_vote"},  32'(vote(f)), 32'(ew));
        @(posedge clk);
        #1;
        check({name, "_idle"}, {29'd0, tx, busy, in_rdy}, {29'd0, 1'b1, 1'b0, 1'b1});
    endtask

    initial begin
        rst = 1'b1;
        in_val = 1'b0;
        in_data = '0;

        vt[0] = '{8'hA5, 30'b111_111_000_111_000_000_111_000_111_000};
        vt[1] = '{8'h00, {3'b111, 27'd0}};
        vt[2] = '{8'hFF, {27'h7FF_FFFF, 3'b000}};
        vt[3] = '{8'h3C, 30'b111_000_000_111_111_111_111_000_000_000};
        for (int i = 4; i < 6; i++) begin
            vt[i].data  = NB'($urandom_range(255));
            vt[i].frame = model_frame(vt[i].data);
        end

        #12;
        check("reset", {29'd0, tx, busy, in_rdy}, {29'd0, 1'b1, 1'b0, 1'b1});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(vt[i].data, vt[i].frame, 1'b0);
            capture($sformatf("vec%0d", i), 1'b0);
        end

        // in_val held high across two words: one IDLE cycle separates the frames
        send(8'h3C, model_frame(8'h3C), 1'b1);
        capture("held0", 1'b0);
        send(8'hC3, model_frame(8'hC3), 1'b1);
        in_val = 1'b0;
        capture("held1", 1'b0);

        // in_data scrambled every cycle after the handshake
        send(8'h5A, model_frame(8'h5A), 1'b0);
        capture("stable", 1'b1);

        // asynchronous reset during DATA bit 3 (bit 3 of 0xF7 is 0)
        @(negedge clk);
        in_val = 1'b1;
        in_data = 8'hF7;
        @(posedge clk);
        #1;
        in_val = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_rst", {30'd0, tx, busy}, {30'd0, 1'b0, 1'b1});
        #1 rst = 1'b1;
        #1;
        check("mid_rst", {29'd0, tx, busy, in_rdy}, {29'd0, 1'b1, 1'b0, 1'b1});
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        #1 rst = 1'b0;

        send(8'h81, model_frame(8'h81), 1'b0);
        capture("post_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
